game_tick_scheduler: RTL and testbench

Consumes the free-running frame timer value (cur_time) and its wrap interval, and turns each wrap into a one-cycle frame_tick. From frame ticks it derives PacMan and ghost movement strobes and runs the ghost mode state machine: scatter/chase alternation plus frightened mode started by a power pellet. It sits between the frame timer and the PacMan and ghost movement/AI logic.

---
 rtl/game_tick_scheduler.sv | 140 ++++++++++++++
 tb/tb_game_tick_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Frame tick scheduler: turns frame-timer wraps into tick/step strobes and runs
// the ghost mode sequence (scatter/chase alternation, pellet-driven fright).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   SCATTER | ghosts head for corners; phase_cnt counts toward SCATTER_TICKS
//   CHASE   | ghosts pursue PacMan; phase_cnt counts toward CHASE_TICKS
//   FRIGHT  | pellet active; phase_cnt frozen, saved_mode restored on expiry
module game_tick_scheduler #(
   parameter int PAC_DIV          = 2,
   parameter int GHOST_DIV        = 3,
   parameter int GHOST_FRIGHT_DIV = 5,
   parameter int SCATTER_TICKS    = 420,
   parameter int CHASE_TICKS      = 1200,
   parameter int FRIGHT_TICKS     = 360,
   parameter int WARN_TICKS       = 120
) (
   input  logic        clock_50,
   input  logic        reset,
   input  logic [27:0] cur_time,
   input  logic [27:0] interval,
   input  logic        enable,
   input  logic        power_pellet,
   output logic        frame_tick,
   output logic        pacman_step,
   output logic        ghost_step,
   output logic [1:0]  mode,
   output logic        ghost_reverse,
   output logic [11:0] fright_remaining,
   output logic        fright_warn
);

   localparam int GMAX  = (GHOST_DIV > GHOST_FRIGHT_DIV) ? GHOST_DIV : GHOST_FRIGHT_DIV;
   localparam int PAC_W = $clog2(PAC_DIV + 1);
   localparam int GW    = $clog2(GMAX + 1);

   typedef enum logic [1:0] {SCATTER = 2'd0, CHASE = 2'd1, FRIGHT = 2'd2} mode_t;

   mode_t            mode_q, mode_nxt, saved_mode, saved_nxt;
   logic [11:0]      phase_cnt, phase_nxt, fright_nxt, phase_last;
   logic [PAC_W-1:0] pac_cnt, pac_nxt;
   logic [GW-1:0]    ghost_cnt, ghost_nxt, ghost_last;
   logic             tick_det, reverse_nxt, fright_entry, fright_exit;
   logic             pstep_nxt, gstep_nxt, warn_nxt;

   assign tick_det   = enable && (cur_time == interval);
   assign mode       = mode_q;
   assign phase_last = (mode_q == SCATTER) ? 12'(SCATTER_TICKS - 1) : 12'(CHASE_TICKS - 1);
   // divisor follows the mode held before the edge, even on the entry edge
   assign ghost_last = (mode_q == FRIGHT) ? GW'(GHOST_FRIGHT_DIV - 1) : GW'(GHOST_DIV - 1);

   always_ff @(posedge clock_50) begin
      if (reset) begin
         mode_q           <= SCATTER;
         saved_mode       <= SCATTER;
         phase_cnt        <= '0;
         fright_remaining <= '0;
         pac_cnt          <= '0;
         ghost_cnt        <= '0;
         frame_tick       <= 1'b0;
         pacman_step      <= 1'b0;
         ghost_step       <= 1'b0;
         ghost_reverse    <= 1'b0;
         fright_warn      <= 1'b0;
      end else begin
         mode_q           <= mode_nxt;
         saved_mode       <= saved_nxt;
         phase_cnt        <= phase_nxt;
         fright_remaining <= fright_nxt;
         pac_cnt          <= pac_nxt;
         ghost_cnt        <= ghost_nxt;
         frame_tick       <= tick_det;
         pacman_step      <= pstep_nxt;
         ghost_step       <= gstep_nxt;
         ghost_reverse    <= reverse_nxt;
         fright_warn      <= warn_nxt;
      end
   end

   // pellet outranks the tick for mode and fright countdown
   always_comb begin
      mode_nxt     = mode_q;
      saved_nxt    = saved_mode;
      phase_nxt    = phase_cnt;
      fright_nxt   = fright_remaining;
      reverse_nxt  = 1'b0;
      fright_entry = 1'b0;
      fright_exit  = 1'b0;
      if (power_pellet) begin
         mode_nxt   = FRIGHT;
         fright_nxt = 12'(FRIGHT_TICKS);
         if (mode_q != FRIGHT) begin
            saved_nxt    = mode_q;
            reverse_nxt  = 1'b1;
            fright_entry = 1'b1;
         end
      end else if (tick_det) begin
         if (mode_q == FRIGHT) begin
            if (fright_remaining == 12'd1) begin
               fright_nxt  = '0;
               mode_nxt    = saved_mode;
               fright_exit = 1'b1;
            end else begin
               fright_nxt = fright_remaining - 12'd1;
            end
         end else if (phase_cnt == phase_last) begin
            if (mode_q == SCATTER) mode_nxt = CHASE;
            else                   mode_nxt = SCATTER;
            phase_nxt   = '0;
            reverse_nxt = 1'b1;
         end else begin
            phase_nxt = phase_cnt + 12'd1;
         end
      end
   end

   always_comb begin
      pac_nxt   = pac_cnt;
      ghost_nxt = ghost_cnt;
      pstep_nxt = 1'b0;
      gstep_nxt = 1'b0;
      if (tick_det) begin
         if (pac_cnt == PAC_W'(PAC_DIV - 1)) begin
            pstep_nxt = 1'b1;
            pac_nxt   = '0;
         end else begin
            pac_nxt = pac_cnt + 1'b1;
         end
         if (ghost_cnt == ghost_last) begin
            gstep_nxt = 1'b1;
            ghost_nxt = '0;
         end else begin
            ghost_nxt = ghost_cnt + 1'b1;
         end
      end
      if (fright_entry || fright_exit) ghost_nxt = '0;
      warn_nxt = (mode_nxt == FRIGHT) && (fright_nxt <= 12'(WARN_TICKS));
   end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with shortened phase/fright lengths.
module tb_game_tick_scheduler;

   logic        clock_50 = 1'b0;
   logic        reset, enable, power_pellet;
   logic [27:0] cur_time, interval;
   logic        frame_tick, pacman_step, ghost_step, ghost_reverse, fright_warn;
   logic [1:0]  mode;
   logic [11:0] fright_remaining;
   int          checks = 0;
   int          errors = 0;

   game_tick_scheduler #(
      .PAC_DIV(2), .GHOST_DIV(3), .GHOST_FRIGHT_DIV(5),
      .SCATTER_TICKS(7), .CHASE_TICKS(20), .FRIGHT_TICKS(6), .WARN_TICKS(2)
   ) dut (
      .clock_50(clock_50), .reset(reset), .cur_time(cur_time), .interval(interval),
      .enable(enable), .power_pellet(power_pellet), .frame_tick(frame_tick),
      .pacman_step(pacman_step), .ghost_step(ghost_step), .mode(mode),
      .ghost_reverse(ghost_reverse), .fright_remaining(fright_remaining),
      .fright_warn(fright_warn)
   );

   always #10 clock_50 = ~clock_50;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [27:0] ct, input logic pel);
      @(negedge clock_50);
      cur_time     = ct;
      power_pellet = pel;
      @(posedge clock_50);
      #1;
      power_pellet = 1'b0;
   endtask

   // cur_time runs 0..3; outputs of the wrap edge are visible on return
   task automatic do_tick(input logic pel);
      step(28'd0, 1'b0);
      step(28'd1, 1'b0);
      step(28'd2, 1'b0);
      step(28'd3, pel);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; cur_time = '0; interval = 28'd3; power_pellet = 1'b0;
      step(28'd0, 1'b0);
      step(28'd0, 1'b0);
      chk("rst_mode", 32'(mode), 0);
      chk("rst_fright", 32'(fright_remaining), 0);
      chk("rst_pulses", {28'd0, frame_tick, pacman_step, ghost_step, ghost_reverse}, 0);
      chk("rst_warn", 32'(fright_warn), 0);
      reset = 1'b0; enable = 1'b1;

      for (int n = 1; n <= 6; n++) begin
         do_tick(1'b0);
         chk("tick_ft", 32'(frame_tick), 1);
         chk("tick_pac", 32'(pacman_step), 32'(n % 2 == 0));
         chk("tick_ghost", 32'(ghost_step), 32'(n % 3 == 0));
         chk("tick_mode", 32'(mode), 0);
      end
      step(28'd0, 1'b0);
      chk("ft_width", 32'(frame_tick), 0);
      chk("pac_width", 32'(pacman_step), 0);

      for (int n = 7; n <= 27; n++) begin
         do_tick(1'b0);
         chk("phase_mode", 32'(mode), (n == 27) ? 0 : 1);
         chk("phase_rev", 32'(ghost_reverse), 32'(n == 7 || n == 27));
      end
      for (int n = 28; n <= 31; n++) do_tick(1'b0);

      step(28'd0, 1'b1);
      chk("entry_mode", 32'(mode), 2);
      chk("entry_fr", 32'(fright_remaining), 6);
      chk("entry_rev", 32'(ghost_reverse), 1);
      chk("entry_warn", 32'(fright_warn), 0);
      chk("entry_ft", 32'(frame_tick), 0);
      step(28'd0, 1'b0);
      chk("entry_rev_width", 32'(ghost_reverse), 0);

      for (int k = 1; k <= 6; k++) begin
         do_tick(1'b0);
         chk("fr_count", 32'(fright_remaining), 32'(6 - k));
         chk("fr_mode", 32'(mode), (k == 6) ? 0 : 2);
         chk("fr_warn", 32'(fright_warn), 32'(k == 4 || k == 5));
         chk("fr_rev", 32'(ghost_reverse), 0);
         chk("fr_ghost", 32'(ghost_step), 32'(k == 5));
         chk("fr_pac", 32'(pacman_step), 32'(k % 2 == 1));
      end

      for (int n = 38; n <= 40; n++) begin
         do_tick(1'b0);
         chk("resume_mode", 32'(mode), (n == 40) ? 1 : 0);
         chk("resume_rev", 32'(ghost_reverse), 32'(n == 40));
         chk("resume_ghost", 32'(ghost_step), 32'(n == 40));
      end

      step(28'd0, 1'b1);
      chk("entry2_mode", 32'(mode), 2);
      chk("entry2_rev", 32'(ghost_reverse), 1);
      for (int k = 1; k <= 5; k++) begin
         do_tick(1'b0);
         chk("fr2_count", 32'(fright_remaining), 32'(6 - k));
         chk("fr2_warn", 32'(fright_warn), 32'(k >= 4));
         chk("fr2_ghost", 32'(ghost_step), 32'(k == 5));
      end
      step(28'd0, 1'b1);
      chk("reload_fr", 32'(fright_remaining), 6);
      chk("reload_rev", 32'(ghost_reverse), 0);
      chk("reload_mode", 32'(mode), 2);
      chk("reload_warn", 32'(fright_warn), 0);

      do_tick(1'b1);
      chk("coinc_ft", 32'(frame_tick), 1);
      chk("coinc_fr", 32'(fright_remaining), 6);
      chk("coinc_rev", 32'(ghost_reverse), 0);
      chk("coinc_pac", 32'(pacman_step), 1);
      chk("coinc_ghost", 32'(ghost_step), 0);
      do_tick(1'b0);
      do_tick(1'b0);
      chk("pre_pause_fr", 32'(fright_remaining), 4);

      enable = 1'b0;
      for (int c = 0; c < 25; c++) begin
         step(28'd3, 1'b0);
         chk("pause_strobes", {29'd0, frame_tick, pacman_step, ghost_step}, 0);
         chk("pause_fr", 32'(fright_remaining), 4);
      end
      step(28'd3, 1'b1);
      chk("pause_pellet_fr", 32'(fright_remaining), 6);
      chk("pause_pellet_rev", 32'(ghost_reverse), 0);
      for (int c = 0; c < 25; c++) begin
         step(28'd3, 1'b0);
         chk("pause2_ft", 32'(frame_tick), 0);
         chk("pause2_fr", 32'(fright_remaining), 6);
      end
      enable = 1'b1;

      for (int k = 1; k <= 3; k++) do_tick(1'b0);
      chk("pre_reset_fr", 32'(fright_remaining), 3);
      chk("pre_reset_mode", 32'(mode), 2);

      reset = 1'b1;
      step(28'd3, 1'b0);
      reset = 1'b0;
      chk("mid_rst_mode", 32'(mode), 0);
      chk("mid_rst_fr", 32'(fright_remaining), 0);
      chk("mid_rst_pulses", {28'd0, frame_tick, pacman_step, ghost_step, ghost_reverse}, 0);
      chk("mid_rst_warn", 32'(fright_warn), 0);

      do_tick(1'b0);
      chk("post_rst_ft", 32'(frame_tick), 1);
      chk("post_rst_pac1", 32'(pacman_step), 0);
      do_tick(1'b0);
      chk("post_rst_pac2", 32'(pacman_step), 1);
      do_tick(1'b0);
      chk("post_rst_ghost3", 32'(ghost_step), 1);
      chk("post_rst_mode", 32'(mode), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
